mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- SRAM/IO access sequencer between the SLC-3 control FSM and the off-chip 16-bit SRAM.
- Converts a single-cycle memory request (address from MAR, data from MDR) into correctly timed active-low SRAM strobes, and returns read data with a one-cycle acknowledge pulse.
- Address 0xFFFF is memory-mapped I/O: reads return the board switches, writes update the hex-display register.
- The control FSM waits on Mem_Ack instead of counting fixed memory states.

Parameters:
- WAIT_CYCLES, 2: cycles OE/WE are held asserted per SRAM access; must be ≥1; elaboration error if 0.
- IO_ADDR, 16'hFFFF: memory-mapped I/O address.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Mem_Req  in  1  request strobe from the control FSM; sampled only in IDLE.
- Mem_Write  in  1  1 = write, 0 = read; sampled with Mem_Req.
- Addr  in  16  word address (MAR).
- Wr_Data  in  16  write data (MDR).
- Switches  in  16  board switches, read at IO_ADDR.
- Rd_Data  out  16  registered read data, held until the next completed read.
- Mem_Ack  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except IDLE.
- SRAM_Addr  out  20  {4'b0, latched Addr}.
- SRAM_Dout  out  16  latched write data.
- SRAM_Din  in  16  data returned by the SRAM.
- Data_Drive  out  1  tristate enable for the SRAM data bus.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
- Hex_Out  out  16  hex-display register.

Behaviour:
- Reset (asynchronous): state IDLE; Mem_OE=Mem_WE=Mem_CE=Mem_UB=Mem_LB=1; Data_Drive=0; Mem_Ack=0; Rd_Data=0; Hex_Out=0; address and data latches cleared. Reset mid-access aborts it immediately. No Ack is issued for the aborted access.
- Strobes, Data_Drive and Mem_Ack come from flops (glitch-free); their values are fixed by the current state only.
- Request acceptance, in IDLE with Mem_Req=1: latch Addr, Wr_Data and Mem_Write. Then branch:
  - Addr==IO_ADDR → IO_DONE.
  - Read → RD_WAIT.
  - Write → WR_SETUP.
- Mem_Req outside IDLE is ignored; it is not queued. A Req held high through the Ack cycle is accepted again on the next IDLE cycle.
- RD_WAIT, WAIT_CYCLES cycles:
  - CE=UB=LB=OE=0; wait counter loads WAIT_CYCLES-1 and counts down.
  - At count 0, Rd_Data<=SRAM_Din; go to RD_DONE.
- RD_DONE, 1 cycle: strobes inactive; Mem_Ack=1; go to IDLE.
- Read latency: Req at cycle 0 → Ack at cycle WAIT_CYCLES+1.
- WR_SETUP, 1 cycle: CE=UB=LB=0; Data_Drive=1; WE=1.
- WR_PULSE, WAIT_CYCLES cycles: WE=0; Data_Drive=1.
- WR_HOLD, 1 cycle: WE=1; Data_Drive=1; Mem_Ack=1; go to IDLE.
- Write latency: Ack at cycle WAIT_CYCLES+2.
- Write timing rules: address and data stay stable for the whole write, one cycle before and one cycle after the WE pulse. OE=1 throughout the write.
- IO_DONE, 1 cycle:
  - Read: Rd_Data<=Switches.
  - Write: Hex_Out<=latched Wr_Data.
  - Mem_Ack=1; no SRAM strobe asserted; go to IDLE.
  - Latency 1 cycle.
- Mem_OE and Mem_WE are never both 0. Data_Drive is never 1 while OE=0.
- Illegal or unreached state encoding → IDLE.
- Addresses wrap naturally; no range checks other than the IO_ADDR decode.

Decomposition:
- Package mem_seq_pkg: state enum {IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, IO_DONE}, IO_ADDR default, strobe-inactive constant.
- Sub-module sync_2ff, 16-bit: two-flop synchronizer for Switches, reset to 0. It adds 2 cycles of input lag to switch changes.
- FSM, counter and datapath latches stay in one module.

Test Plan:
- Reset during RD_WAIT (Reset_n low mid-access) → strobes all 1 asynchronously, Ack never pulses, state IDLE, Rd_Data=0.
- SRAM read, WAIT_CYCLES=2, Addr=0x0010, SRAM model returns 0xBEEF:
  - OE low on cycles 1–2; Ack on cycle 3.
  - Rd_Data=0xBEEF from cycle 3; SRAM_Addr=0x00010.
- SRAM write, Addr=0x1234, Wr_Data=0xA5A5:
  - Data_Drive high cycles 1–4; WE low cycles 2–3 only; Ack cycle 4.
  - A subsequent read of 0x1234 returns 0xA5A5.
- I/O:
  - Write Addr=0xFFFF, Wr_Data=0x00C3 → Hex_Out=0x00C3 and Ack on cycle 1, no strobe toggles.
  - With Switches=0x5A5A held ≥3 cycles, read 0xFFFF → Rd_Data=0x5A5A.
- Mem_Req held high continuously with Mem_Write=0, Addr=0x0001 → back-to-back reads, one Ack every WAIT_CYCLES+2 cycles, Busy low exactly 1 cycle between them.
- Protocol checker over random traffic with WAIT_CYCLES=1 and 4 → assert OE/WE never both low, Data_Drive never high while OE low, exactly one Ack per accepted Req.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the SLC-3 SRAM/IO access sequencer.
package mem_seq_pkg;

    // Sequencer states; explicit encodings keep waveforms comparable with older builds.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DONE  = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        IO_DONE  = 3'd6
    } state_e;

    // Default memory-mapped I/O address (switches on read, hex display on write).
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // Registered control outputs; SRAM strobes are active-low.
    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
        logic drive;
        logic ack;
    } ctl_t;

    // All strobes released, bus not driven, no acknowledge.
    localparam ctl_t CTL_IDLE = '{
        ce:    1'b1,
        ub:    1'b1,
        lb:    1'b1,
        oe:    1'b1,
        we:    1'b1,
        drive: 1'b0,
        ack:   1'b0
    };

    // Output pattern owned by each state; the top registers this for the next state.
    function automatic ctl_t state_ctl(input state_e s);
        ctl_t c;
        c = CTL_IDLE;
        case (s)
            RD_WAIT: begin
                c.ce = 1'b0;
                c.ub = 1'b0;
                c.lb = 1'b0;
                c.oe = 1'b0;
            end
            RD_DONE: begin
                c.ack = 1'b1;
            end
            WR_SETUP: begin
                c.ce    = 1'b0;
                c.ub    = 1'b0;
                c.lb    = 1'b0;
                c.drive = 1'b1;
            end
            WR_PULSE: begin
                c.ce    = 1'b0;
                c.ub    = 1'b0;
                c.lb    = 1'b0;
                c.we    = 1'b0;
                c.drive = 1'b1;
            end
            WR_HOLD: begin
                c.ce    = 1'b0;
                c.ub    = 1'b0;
                c.lb    = 1'b0;
                c.drive = 1'b1;
                c.ack   = 1'b1;
            end
            IO_DONE: begin
                c.ack = 1'b1;
            end
            default: c = CTL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs (switches).
module sync_2ff #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; q lags d by two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// SRAM/IO access sequencer: turns a one-cycle request from the SLC-3 control
// FSM into timed active-low SRAM strobes and returns a one-cycle Mem_Ack.
// Address IO_ADDR is decoded to the switch input / hex display register.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_Req,
    input  logic        Mem_Write,
    input  logic [15:0] Addr,
    input  logic [15:0] Wr_Data,
    input  logic [15:0] Switches,
    output logic [15:0] Rd_Data,
    output logic        Mem_Ack,
    output logic        Busy,
    output logic [19:0] SRAM_Addr,
    output logic [15:0] SRAM_Dout,
    input  logic [15:0] SRAM_Din,
    output logic        Data_Drive,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] Hex_Out
);

    if (WAIT_CYCLES == 0) begin : g_wait_check
        $error("mem_sequencer: WAIT_CYCLES must be at least 1");
    end

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    ctl_t              ctl_q;
    logic [15:0]       addr_q;
    logic [15:0]       data_q;
    logic [15:0]       switches_sync;
    logic              accept;
    logic              io_hit;

    sync_2ff #(
        .WIDTH(16)
    ) u_sw_sync (
        .clk   (Clk),
        .rst_n (Reset_n),
        .d     (Switches),
        .q     (switches_sync)
    );

    assign accept = (state == IDLE) && Mem_Req;
    assign io_hit = (Addr == IO_ADDR);

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (Mem_Req) begin
                    if (io_hit) begin
                        state_nxt = IO_DONE;
                    end else if (Mem_Write) begin
                        state_nxt = WR_SETUP;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RD_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RD_DONE: state_nxt = IDLE;
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = CNT_LOAD;
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = WR_HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WR_HOLD:  state_nxt = IDLE;
            IO_DONE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State, counter and registered strobes; strobes are decoded from the
    // next state so their flop outputs track the current state exactly.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            ctl_q <= CTL_IDLE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ctl_q <= state_ctl(state_nxt);
        end
    end

    // Address and write-data latches, loaded only when a request is accepted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            addr_q <= Addr;
            data_q <= Wr_Data;
        end
    end

    // Read-data register: SRAM data at the end of the wait window, switches for I/O.
    // The I/O result is committed on the accepting edge (Wr_Data equals the
    // latched value there) so it is already valid during the IO_DONE Ack cycle,
    // matching the SRAM read path where Rd_Data is valid alongside Ack.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Rd_Data <= '0;
        end else if (state == RD_WAIT && cnt == '0) begin
            Rd_Data <= SRAM_Din;
        end else if (accept && io_hit && !Mem_Write) begin
            Rd_Data <= switches_sync;
        end
    end

    // Hex display register, written by an I/O store.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Hex_Out <= '0;
        end else if (accept && io_hit && Mem_Write) begin
            Hex_Out <= Wr_Data;
        end
    end

    assign Busy       = (state != IDLE);
    assign SRAM_Addr  = {4'b0000, addr_q};
    assign SRAM_Dout  = data_q;
    assign Data_Drive = ctl_q.drive;
    assign Mem_CE     = ctl_q.ce;
    assign Mem_UB     = ctl_q.ub;
    assign Mem_LB     = ctl_q.lb;
    assign Mem_OE     = ctl_q.oe;
    assign Mem_WE     = ctl_q.we;
    assign Mem_Ack    = ctl_q.ack;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: three instances (WAIT_CYCLES 2, 1, 4) with an SRAM
// fixture each, directed timing steps, randomized traffic and protocol monitors.
module tb_mem_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        req   [3];
    logic        wr    [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic [15:0] sw    [3];
    logic [15:0] rd_data [3];
    logic        ack   [3];
    logic        busy  [3];
    logic [19:0] sram_addr [3];
    logic [15:0] sram_dout [3];
    logic [15:0] sram_din  [3];
    logic        dd    [3];
    logic        ce    [3];
    logic        ub    [3];
    logic        lb    [3];
    logic        oe    [3];
    logic        we    [3];
    logic [15:0] hex   [3];

    int n_chk = 0;
    int n_fail = 0;
    int n_acc [3];
    int n_ack [3];

    logic [15:0] fix_mem [int];
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rd  [3];
    logic [15:0] exp_hex [3];

    function automatic int wc(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    function automatic int key(input int i, input logic [15:0] a);
        return i * 65536 + int'(a);
    endfunction

    function automatic logic [15:0] dflt(input int k);
        return 16'(k * 40503 + 7);
    endfunction

    function automatic logic [15:0] ref_rd(input int i, input logic [15:0] a);
        int k;
        k = key(i, a);
        return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
    endfunction

    // Latency of a transaction, straight from the access rules.
    function automatic int exp_lat(input int i, input logic w, input logic [15:0] a);
        if (a == 16'hFFFF) return 1;
        return w ? wc(i) + 2 : wc(i) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_sequencer #(
            .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
            .IO_ADDR     (16'hFFFF)
        ) dut (
            .Clk        (clk),
            .Reset_n    (rst_n[g]),
            .Mem_Req    (req[g]),
            .Mem_Write  (wr[g]),
            .Addr       (addr[g]),
            .Wr_Data    (wdata[g]),
            .Switches   (sw[g]),
            .Rd_Data    (rd_data[g]),
            .Mem_Ack    (ack[g]),
            .Busy       (busy[g]),
            .SRAM_Addr  (sram_addr[g]),
            .SRAM_Dout  (sram_dout[g]),
            .SRAM_Din   (sram_din[g]),
            .Data_Drive (dd[g]),
            .Mem_CE     (ce[g]),
            .Mem_UB     (ub[g]),
            .Mem_LB     (lb[g]),
            .Mem_OE     (oe[g]),
            .Mem_WE     (we[g]),
            .Hex_Out    (hex[g])
        );

        // SRAM fixture: store while CE and WE are low.
        always @(posedge clk) begin
            if (rst_n[g] && !ce[g] && !we[g])
                fix_mem[key(g, sram_addr[g][15:0])] = sram_dout[g];
        end

        // SRAM fixture: present data for the latched address mid-cycle.
        always @(negedge clk) begin
            int k;
            k = key(g, sram_addr[g][15:0]);
            sram_din[g] = fix_mem.exists(k) ? fix_mem[k] : dflt(k);
        end

        // Protocol monitor and request/acknowledge accounting.
        always @(negedge clk) begin
            if (rst_n[g]) begin
                chk("oe_we_both_low", {31'b0, (!oe[g] && !we[g])}, 32'd0);
                chk("drive_while_oe_low", {31'b0, (dd[g] && !oe[g])}, 32'd0);
                if (!busy[g] && req[g]) n_acc[g]++;
                if (ack[g]) n_ack[g]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request at the current cycle (cycle 0) and trace cycles until Ack.
    task automatic txn(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int ack_c, output logic [31:0] oe_m, output logic [31:0] we_m,
                       output logic [31:0] dd_m, output logic [31:0] any_m,
                       output logic [15:0] ack_rd, output logic [15:0] ack_hex);
        req[i]   = 1'b1;
        wr[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        ack_c    = -1;
        oe_m     = '0;
        we_m     = '0;
        dd_m     = '0;
        any_m    = '0;
        ack_rd   = '0;
        ack_hex  = '0;
        tick();
        req[i]   = 1'b0;
        addr[i]  = 16'($urandom);
        wdata[i] = 16'($urandom);
        for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            if (!oe[i]) oe_m[c] = 1'b1;
            if (!we[i]) we_m[c] = 1'b1;
            if (dd[i])  dd_m[c] = 1'b1;
            if (!ce[i] || !ub[i] || !lb[i] || !oe[i] || !we[i] || dd[i]) any_m[c] = 1'b1;
            if (ack[i]) begin
                ack_c   = c;
                ack_rd  = rd_data[i];
                ack_hex = hex[i];
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        int          ac;
        logic [31:0] m_oe, m_we, m_dd, m_any;
        logic [15:0] r_rd, r_hex;
        logic        w;
        logic [15:0] a, d;
        bit          b2b_ack, b2b_busy;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            req[i]   = 1'b0;
            wr[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
            sw[i]    = '0;
            n_acc[i] = 0;
            n_ack[i] = 0;
            exp_rd[i]  = '0;
            exp_hex[i] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_strobes", {27'b0, ce[i], ub[i], lb[i], oe[i], we[i]}, 32'h1F);
            chk("rst_drive_ack_busy", {29'b0, dd[i], ack[i], busy[i]}, 32'd0);
            chk("rst_rd_data", rd_data[i], 32'd0);
            chk("rst_hex", hex[i], 32'd0);
            chk("rst_sram_addr", sram_addr[i], 32'd0);
            rst_n[i] = 1'b1;
        end
        tick();

        // SRAM read of 0x0010 returning 0xBEEF.
        fix_mem[key(0, 16'h0010)] = 16'hBEEF;
        ref_mem[key(0, 16'h0010)] = 16'hBEEF;
        txn(0, 1'b0, 16'h0010, 16'h0000, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        chk("rd_ack_cycle", ac, 32'd3);
        chk("rd_oe_cycles", m_oe, 32'h6);
        chk("rd_we_cycles", m_we, 32'h0);
        chk("rd_data_at_ack", r_rd, 32'hBEEF);
        chk("rd_sram_addr", sram_addr[0], 32'h00010);
        exp_rd[0] = 16'hBEEF;

        // I/O write to the hex display.
        txn(0, 1'b1, 16'hFFFF, 16'h00C3, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        chk("io_wr_ack_cycle", ac, 32'd1);
        chk("io_wr_no_strobes", m_any, 32'h0);
        chk("io_wr_hex_at_ack", r_hex, 32'h00C3);
        chk("io_wr_rd_held", r_rd, 32'hBEEF);
        exp_hex[0] = 16'h00C3;

        // SRAM write of 0xA5A5 to 0x1234, then read it back.
        txn(0, 1'b1, 16'h1234, 16'hA5A5, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        ref_mem[key(0, 16'h1234)] = 16'hA5A5;
        chk("wr_ack_cycle", ac, 32'd4);
        chk("wr_drive_cycles", m_dd, 32'h1E);
        chk("wr_we_cycles", m_we, 32'h0C);
        chk("wr_oe_cycles", m_oe, 32'h0);
        chk("wr_sram_dout", sram_dout[0], 32'hA5A5);
        chk("wr_rd_held", r_rd, 32'hBEEF);
        txn(0, 1'b0, 16'h1234, 16'h0000, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        chk("readback_ack_cycle", ac, 32'd3);
        chk("readback_data", r_rd, ref_rd(0, 16'h1234));

        // Switch reads: settled value, then a change one cycle before the request.
        sw[0] = 16'h5A5A;
        repeat (3) tick();
        txn(0, 1'b0, 16'hFFFF, 16'h0000, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        chk("io_rd_ack_cycle", ac, 32'd1);
        chk("io_rd_switches", r_rd, 32'h5A5A);
        chk("io_rd_no_strobes", m_any, 32'h0);
        sw[0] = 16'h1111;
        repeat (3) tick();
        sw[0] = 16'h2222;
        tick();
        txn(0, 1'b0, 16'hFFFF, 16'h0000, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        chk("io_rd_sync_lag", r_rd, 32'h1111);
        repeat (3) tick();
        txn(0, 1'b0, 16'hFFFF, 16'h0000, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
        chk("io_rd_after_lag", r_rd, 32'h2222);

        // Reset in the middle of a read wait window.
        req[0]  = 1'b1;
        wr[0]   = 1'b0;
        addr[0] = 16'h0020;
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_rd_wait", {31'b0, oe[0]}, 32'd0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("abort_async_strobes", {27'b0, ce[0], ub[0], lb[0], oe[0], we[0]}, 32'h1F);
        chk("abort_async_busy_drive", {30'b0, busy[0], dd[0]}, 32'd0);
        chk("abort_rd_data", rd_data[0], 32'd0);
        chk("abort_hex", hex[0], 32'd0);
        @(negedge clk);
        chk("abort_ack_in_reset", {31'b0, ack[0]}, 32'd0);
        rst_n[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_ack_after", {30'b0, ack[0], busy[0]}, 32'd0);
        end
        tick();
        exp_rd[0]  = '0;
        exp_hex[0] = '0;

        // Mem_Req held high: back-to-back reads of 0x0001.
        req[0]  = 1'b1;
        wr[0]   = 1'b0;
        addr[0] = 16'h0001;
        for (int c = 1; c < 20; c++) begin
            tick();
            @(negedge clk);
            b2b_ack  = (c >= wc(0) + 1) && ((c - (wc(0) + 1)) % (wc(0) + 2) == 0);
            b2b_busy = !((c >= wc(0) + 2) && ((c - (wc(0) + 2)) % (wc(0) + 2) == 0));
            chk("b2b_ack", {31'b0, ack[0]}, {31'b0, b2b_ack});
            chk("b2b_busy", {31'b0, busy[0]}, {31'b0, b2b_busy});
            if (b2b_ack) chk("b2b_rd_data", rd_data[0], ref_rd(0, 16'h0001));
        end
        tick();
        req[0] = 1'b0;
        exp_rd[0] = ref_rd(0, 16'h0001);
        tick();

        // Randomized traffic on every instance against the reference model.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 30; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sw[i] = 16'($urandom);
                    repeat (3) tick();
                end
                w = 1'($urandom_range(0, 1));
                a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'h0100 + 16'($urandom_range(0, 15));
                d = 16'($urandom);
                txn(i, w, a, d, ac, m_oe, m_we, m_dd, m_any, r_rd, r_hex);
                chk("rnd_latency", ac, exp_lat(i, w, a));
                if (a == 16'hFFFF) begin
                    if (w) exp_hex[i] = d;
                    else   exp_rd[i]  = sw[i];
                    chk("rnd_io_no_strobes", m_any, 32'h0);
                end else if (w) begin
                    ref_mem[key(i, a)] = d;
                    chk("rnd_wr_we_cycles", m_we, ((32'd1 << wc(i)) - 32'd1) << 2);
                end else begin
                    exp_rd[i] = ref_rd(i, a);
                    chk("rnd_rd_oe_cycles", m_oe, ((32'd1 << wc(i)) - 32'd1) << 1);
                end
                chk("rnd_rd_data", r_rd, exp_rd[i]);
                chk("rnd_hex", r_hex, exp_hex[i]);
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        repeat (2) tick();
        for (int i = 0; i < 3; i++)
            chk("accepts_minus_acks", n_acc[i] - n_ack[i], (i == 0) ? 32'd1 : 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
